// File: rtl/nekov_pkg.sv
// Shared definitions for the nekov core front end: datapath width, the NOP encoding
// and the instruction-fetch FSM state type.
package nekov_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, VALID} ifetch_state_t;

endpackage

// File: rtl/instruction_fetch.sv
// Instruction fetch: reads the PC, issues one memory request at a time and holds the
// returned word for decode. IFETCH_MISALIGN_TRAP_EN enables the misaligned-fetch fault.
module instruction_fetch #(
  parameter int unsigned    XLEN        = nekov_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_INSTR = nekov_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_en,
  input  logic [XLEN-1:0] pc,
  output logic            pc_count,
  input  logic            flush,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr_data,
  output logic [XLEN-1:0] instr_pc,
  input  logic            decode_ready,
  output logic            fetch_fault
);
  import nekov_pkg::*;

  ifetch_state_t   state_q, state_d;
  logic            discard_q, discard_d;
  logic            fault_q, fault_d;
  logic [XLEN-1:0] data_q, data_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            misaligned;

`ifdef IFETCH_MISALIGN_TRAP_EN
  assign misaligned = |pc[1:0];
  assign imem_addr  = pc;
`else
  assign misaligned = 1'b0;
  assign imem_addr  = {pc[XLEN-1:2], 2'b00};
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      discard_q <= 1'b0;
      fault_q   <= 1'b0;
      data_q    <= RESET_INSTR;
      pc_q      <= '0;
      req_pc_q  <= '0;
    end else begin
      discard_q <= discard_d;
      fault_q   <= fault_d;
      data_q    <= data_d;
      pc_q      <= pc_d;
      req_pc_q  <= req_pc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    discard_d = discard_q;
    fault_d   = fault_q;
    data_d    = data_q;
    pc_d      = pc_q;
    req_pc_d  = req_pc_q;
    unique case (state_q)
      IDLE: begin
        if (fetch_en) state_d = REQ;
      end
      REQ: begin
        if (misaligned) begin
          // A flush rewrites the PC this cycle, so the fault is re-evaluated next cycle.
          if (!flush) begin
            state_d = VALID;
            fault_d = 1'b1;
            data_d  = RESET_INSTR;
            pc_d    = pc;
          end
        end else if (imem_gnt) begin
          state_d   = WAIT;
          req_pc_d  = pc;
          discard_d = flush;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (discard_q || flush) begin
            discard_d = 1'b0;
            state_d   = fetch_en ? REQ : IDLE;
          end else begin
            data_d  = imem_rdata;
            pc_d    = req_pc_q;
            state_d = VALID;
          end
        end else if (flush) begin
          discard_d = 1'b1;
        end
      end
      VALID: begin
        if (flush) begin
          state_d = REQ;
          fault_d = 1'b0;
        end else if (decode_ready) begin
          state_d = fetch_en ? REQ : IDLE;
          fault_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    imem_req    = (state_q == REQ) && !misaligned;
    pc_count    = imem_req && imem_gnt && !flush;
    instr_valid = (state_q == VALID);
    instr_data  = instr_valid ? data_q : RESET_INSTR;
    instr_pc    = pc_q;
`ifdef IFETCH_MISALIGN_TRAP_EN
    fetch_fault = instr_valid && fault_q;
`else
    fetch_fault = 1'b0;
`endif
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a transaction-level scoreboard and a
// behavioural memory / program-counter model.
module tb_instruction_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_en;
  logic [31:0] pc;
  logic        pc_count;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        decode_ready;
  logic        fetch_fault;

  int checks = 0;
  int errors = 0;

  instruction_fetch dut (
    .clk          (clk),
    .reset        (reset),
    .fetch_en     (fetch_en),
    .pc           (pc),
    .pc_count     (pc_count),
    .flush        (flush),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .instr_valid  (instr_valid),
    .instr_data   (instr_data),
    .instr_pc     (instr_pc),
    .decode_ready (decode_ready),
    .fetch_fault  (fetch_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return {8'hA5, a[23:0]};
  endfunction

  function automatic logic [31:0] exp_addr(input logic [31:0] p);
`ifdef IFETCH_MISALIGN_TRAP_EN
    return p;
`else
    return {p[31:2], 2'b00};
`endif
  endfunction

  // Scoreboard: instructions that must reach decode, in order.
  logic [31:0] exp_data_q[$];
  logic [31:0] exp_pc_q[$];
  logic        exp_fault_q[$];
  logic        m_out = 1'b0, m_kill = 1'b0;
  logic [31:0] m_addr = '0;
  logic        have_cur = 1'b0;
  logic [31:0] cur_data, cur_pc;
  logic        cur_fault;

  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_valid", instr_valid, 0);
      chk("rst_req", imem_req, 0);
      chk("rst_count", pc_count, 0);
      chk("rst_data", instr_data, NOP);
      chk("rst_fault", fetch_fault, 0);
      m_out    = 1'b0;
      have_cur = 1'b0;
      exp_data_q.delete();
      exp_pc_q.delete();
      exp_fault_q.delete();
    end else begin
      chk("pc_count_rule", pc_count, imem_req & imem_gnt & ~flush);
      if (imem_req) begin
        chk("imem_addr", imem_addr, exp_addr(pc));
        chk("one_outstanding", m_out, 0);
      end
      if (!instr_valid) begin
        chk("idle_data", instr_data, NOP);
        chk("idle_fault", fetch_fault, 0);
        chk("valid_dropped", have_cur, 0);
        have_cur = 1'b0;
      end else begin
        if (!have_cur) begin
          if (exp_data_q.size() != 0) begin
            cur_data  = exp_data_q.pop_front();
            cur_pc    = exp_pc_q.pop_front();
            cur_fault = exp_fault_q.pop_front();
            have_cur  = 1'b1;
          end else begin
            checks++;
            errors++;
            $display("FAIL spurious_valid actual=valid pc=%h required=no instruction", instr_pc);
          end
        end
        if (have_cur) begin
          chk("instr_data", instr_data, cur_data);
          chk("instr_pc", instr_pc, cur_pc);
          chk("instr_fault", fetch_fault, cur_fault);
          if (decode_ready || flush) have_cur = 1'b0;
        end
      end
`ifndef IFETCH_MISALIGN_TRAP_EN
      chk("fault_tied", fetch_fault, 0);
`endif
      // A response is delivered only if no flush occurred from grant to data.
      if (imem_req && imem_gnt) begin
        m_out  = 1'b1;
        m_kill = flush;
        m_addr = imem_addr;
      end else if (m_out) begin
        if (flush) m_kill = 1'b1;
        if (imem_rvalid) begin
          if (!m_kill) begin
            exp_data_q.push_back(mem_rd(m_addr));
            exp_pc_q.push_back(m_addr);
            exp_fault_q.push_back(1'b0);
          end
          m_out = 1'b0;
        end
      end
    end
  end

  // Program counter and memory responder, advanced one clock per tick.
  int          lat = 0, cd = 0, n_count = 0, n_req = 0;
  logic        pend = 1'b0;
  logic [31:0] paddr = '0, flush_tgt = '0;

  task automatic tick();
    logic s_acc, s_cnt, s_flush;
    logic [31:0] s_addr;
    @(negedge clk);
    s_acc   = imem_req && imem_gnt;
    s_cnt   = pc_count;
    s_addr  = imem_addr;
    s_flush = flush;
    @(posedge clk);
    #1;
    if (s_acc) n_req++;
    if (s_cnt) begin
      pc = pc + 32'd4;
      n_count++;
    end
    if (s_flush) pc = flush_tgt;
    flush       = 1'b0;
    imem_rvalid = 1'b0;
    if (s_acc) begin
      pend  = 1'b1;
      cd    = lat;
      paddr = s_addr;
    end
    if (pend) begin
      if (cd == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_rd(paddr);
        pend        = 1'b0;
      end else begin
        cd--;
      end
    end
  endtask

  task automatic wait_valid(input int bound);
    int n = 0;
    while (!instr_valid && n < bound) begin
      tick();
      n++;
    end
    chk("wait_valid", instr_valid, 1);
  endtask

  int c0, r0;
  logic [31:0] d0, p0;

  initial begin
    reset = 1'b0; fetch_en = 1'b1; pc = 32'h0; flush = 1'b0; imem_gnt = 1'b1;
    imem_rvalid = 1'b0; imem_rdata = '0; decode_ready = 1'b0;
    tick();
    tick();
    reset = 1'b1;

    // T1: first fetch from 0x0, zero-wait memory.
    chk("t1_cyc0_req", imem_req, 0);
    tick();
    chk("t1_cyc1_req", imem_req, 1);
    chk("t1_cyc1_addr", imem_addr, 32'h0);
    chk("t1_cyc1_count", pc_count, 1);
    tick();
    chk("t1_wait_req", imem_req, 0);
    chk("t1_wait_valid", instr_valid, 0);
    tick();
    chk("t1_valid", instr_valid, 1);
    chk("t1_data", instr_data, 32'h0050_0093);
    chk("t1_pc", instr_pc, 32'h0);
    chk("t1_counts", n_count, 1);

    // T2: decode stalls for 5 cycles.
    c0 = n_count; r0 = n_req; d0 = instr_data; p0 = instr_pc;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_valid", instr_valid, 1);
      chk("t2_data", instr_data, d0);
      chk("t2_pc", instr_pc, p0);
      chk("t2_req", imem_req, 0);
    end
    chk("t2_no_count", n_count, c0);
    chk("t2_no_req", n_req, r0);

    // T3: flush coincident with grant at pc 0x8.
    fetch_en = 1'b0; decode_ready = 1'b1;
    tick();
    decode_ready = 1'b0;
    pc = 32'h8; fetch_en = 1'b1;
    tick();
    c0 = n_count;
    flush = 1'b1; flush_tgt = 32'h40;
    #1;
    chk("t3_req", imem_req, 1);
    chk("t3_addr", imem_addr, 32'h8);
    chk("t3_no_count", pc_count, 0);
    tick();
    chk("t3_dropped", instr_valid, 0);
    wait_valid(20);
    chk("t3_pc", instr_pc, 32'h40);
    chk("t3_data", instr_data, mem_rd(32'h40));
    chk("t3_one_count", n_count - c0, 1);

    // T4: flush while waiting on a slow response.
    lat = 3; decode_ready = 1'b1;
    tick();
    decode_ready = 1'b0;
    tick();
    c0 = n_count;
    flush = 1'b1; flush_tgt = 32'h80;
    tick();
    wait_valid(30);
    chk("t4_pc", instr_pc, 32'h80);
    chk("t4_data", instr_data, mem_rd(32'h80));
    chk("t4_one_count", n_count - c0, 1);

    // Streaming at best-case rate: one instruction per three cycles.
    lat = 0; fetch_en = 1'b0; decode_ready = 1'b1;
    tick();
    pc = 32'h100; fetch_en = 1'b1; c0 = n_count;
    for (int i = 0; i < 12; i++) tick();
    chk("stream_rate", n_count - c0, 4);
    fetch_en = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("stream_idle", instr_valid, 0);

    // T5: reset mid-WAIT, stale response after release.
    lat = 3; fetch_en = 1'b1; decode_ready = 1'b0;
    tick();
    tick();
    chk("t5_pending", pend, 1);
    fetch_en = 1'b0;
    reset = 1'b0;
    #2;
    chk("t5_async_valid", instr_valid, 0);
    chk("t5_async_data", instr_data, NOP);
    chk("t5_async_pc", instr_pc, 32'h0);
    chk("t5_async_req", imem_req, 0);
    tick();
    reset = 1'b1;
    r0 = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (imem_rvalid) r0++;
      chk("t5_no_valid", instr_valid, 0);
    end
    chk("t5_stale_seen", r0, 1);

`ifdef IFETCH_MISALIGN_TRAP_EN
    // T6: misaligned PC traps without touching memory.
    lat = 0; pc = 32'h2; fetch_en = 1'b1; c0 = n_count; r0 = n_req;
    tick();
    exp_data_q.push_back(NOP);
    exp_pc_q.push_back(32'h2);
    exp_fault_q.push_back(1'b1);
    chk("t6_no_req", imem_req, 0);
    chk("t6_no_count", pc_count, 0);
    tick();
    chk("t6_valid", instr_valid, 1);
    chk("t6_fault", fetch_fault, 1);
    chk("t6_pc", instr_pc, 32'h2);
    chk("t6_data", instr_data, NOP);
    chk("t6_mem_untouched", n_req - r0, 0);
    fetch_en = 1'b0; decode_ready = 1'b1;
    tick();
    chk("t6_fault_clr", fetch_fault, 0);
    chk("t6_valid_clr", instr_valid, 0);
`endif

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
